// File: rtl/polyvec_readout_serializer.sv
`default_nettype none
// ============================================================================
// Module   : polyvec_readout_serializer
// Purpose  : Pulls coefficient pairs from the basemul accumulator one index at
//            a time and re-emits them as a 16-bit valid/ready word stream.
//            Optional index check enabled by POLYVEC_READOUT_INDEX_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module polyvec_readout_serializer #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             readout,
    input  logic [WIDTH-1:0] in_dout_1,
    input  logic [WIDTH-1:0] in_dout_2,
    input  logic [DEPTH-1:0] in_index,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic             index_err
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_CAP     = 3'd2,
        S_EMIT_LO = 3'd3,
        S_EMIT_HI = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    localparam logic [DEPTH-1:0] c_LAST_IDX = {DEPTH{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [DEPTH-1:0] r_cnt;
    logic [DEPTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic             r_out_last;

    always_comb begin
        w_next_state = r_state;
        w_cnt_nxt    = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_REQ;
                    w_cnt_nxt    = '0;
                end
            end
            S_REQ:     w_next_state = S_CAP;
            S_CAP:     w_next_state = S_EMIT_LO;
            S_EMIT_LO: begin
                if (out_ready) begin
                    w_next_state = S_EMIT_HI;
                end
            end
            S_EMIT_HI: begin
                if (out_ready) begin
                    if (r_cnt == c_LAST_IDX) begin
                        w_next_state = S_FIN;
                    end else begin
                        w_next_state = S_REQ;
                        w_cnt_nxt    = r_cnt + 1'b1;
                    end
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
                w_cnt_nxt    = '0;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Output word register: loaded with the even coefficient at capture and
    // advanced to the odd one only on the low-word handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (r_state == S_CAP) begin
                r_out_data <= in_dout_1;
                r_hi       <= in_dout_2;
            end else if ((r_state == S_EMIT_LO) && out_ready) begin
                r_out_data <= r_hi;
            end
            r_out_valid <= (w_next_state == S_EMIT_LO) || (w_next_state == S_EMIT_HI);
            r_out_last  <= (w_next_state == S_EMIT_HI) && (w_cnt_nxt == c_LAST_IDX);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign readout   = (r_state == S_REQ);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);

`ifdef POLYVEC_READOUT_INDEX_CHECK_EN
    logic r_index_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_index_err <= 1'b0;
        end else if ((r_state == S_CAP) && (in_index != r_cnt)) begin
            r_index_err <= 1'b1;
        end
    end

    assign index_err = r_index_err;
`else
    logic w_unused_index;

    assign w_unused_index = ^in_index;
    assign index_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_polyvec_readout_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_polyvec_readout_serializer
// Purpose  : Self-checking bench with a scoreboarded accumulator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_polyvec_readout_serializer;

    localparam int DEPTH = 5;
    localparam int WIDTH = 16;
    localparam int NP    = 1 << DEPTH;
    localparam int NW    = 2 * NP;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             readout;
    logic [WIDTH-1:0] in_dout_1 = '0;
    logic [WIDTH-1:0] in_dout_2 = '0;
    logic [DEPTH-1:0] in_index = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             index_err;

    logic             start2 = 1'b0;
    logic             readout2;
    logic [WIDTH-1:0] in2_dout_1 = '0;
    logic [WIDTH-1:0] in2_dout_2 = '0;
    logic [1:0]       in2_index = '0;
    logic [WIDTH-1:0] out2_data;
    logic             out2_valid;
    logic             out2_last;
    logic             busy2;
    logic             done2;
    logic             index_err2;

    polyvec_readout_serializer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_dut (
        .clk(clk), .reset(reset), .start(start), .readout(readout),
        .in_dout_1(in_dout_1), .in_dout_2(in_dout_2), .in_index(in_index),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done), .index_err(index_err)
    );

    polyvec_readout_serializer #(.DEPTH(2), .WIDTH(WIDTH)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .readout(readout2),
        .in_dout_1(in2_dout_1), .in_dout_2(in2_dout_2), .in_index(in2_index),
        .out_data(out2_data), .out_valid(out2_valid), .out_ready(1'b1),
        .out_last(out2_last), .busy(busy2), .done(done2), .index_err(index_err2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accumulator model: answers each readout one cycle later and records the
    // words the serializer owes downstream.
    logic [WIDTH-1:0] exp_q[$];
    int  prod_idx = 0;
    bit  det_mode = 1'b1;
    int  inject_idx = -1;
    int  ready_mode = 0;
    int  ready_phase = 0;
    logic rd_s, rs_s;
    logic [WIDTH-1:0] lo_v, hi_v;

    always @(posedge clk) begin
        rd_s = readout;
        rs_s = reset;
        #1;
        if (rd_s && rs_s) begin
            lo_v = det_mode ? WIDTH'(2 * prod_idx)     : WIDTH'($urandom);
            hi_v = det_mode ? WIDTH'(2 * prod_idx + 1) : WIDTH'($urandom);
            in_dout_1 = lo_v;
            in_dout_2 = hi_v;
            in_index  = DEPTH'((prod_idx == inject_idx) ? inject_idx - 1 : prod_idx);
            exp_q.push_back(lo_v);
            exp_q.push_back(hi_v);
            prod_idx++;
        end else begin
            in_dout_1 = WIDTH'($urandom);
            in_dout_2 = WIDTH'($urandom);
            in_index  = DEPTH'($urandom);
        end
        case (ready_mode)
            1:       begin out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3); ready_phase++; end
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b1;
        endcase
    end

    int p2 = 0;
    logic rd2_s;
    always @(posedge clk) begin
        rd2_s = readout2;
        #1;
        if (rd2_s) begin
            in2_dout_1 = WIDTH'(2 * p2);
            in2_dout_2 = WIDTH'(2 * p2 + 1);
            in2_index  = 2'(p2);
            p2++;
        end
    end

    // Downstream monitor: handshake scoreboard, stall stability, done timing.
    int acc = 0;
    int done_cnt = 0;
    int rd_cnt = 0;
    int last_acc_cyc = -10;
    int done_cyc = 0;
    logic [WIDTH-1:0] prev_data;
    logic prev_last;
    bit   prev_stall = 1'b0;
    logic [WIDTH-1:0] exp_w;

    always @(negedge clk) begin
        if (reset) begin
            if (readout) rd_cnt++;
            chk("readout_while_pending", {31'd0, readout && out_valid}, 32'd0);
            if (prev_stall) begin
                chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
                chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk("word_data", {16'd0, out_data}, {16'd0, exp_w});
                chk("word_last", {31'd0, out_last}, {31'd0, acc == NW - 1});
                if (acc == NW - 1) last_acc_cyc = cyc;
                acc++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("done_after_last", cyc, last_acc_cyc + 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

`ifdef POLYVEC_READOUT_INDEX_CHECK_EN
    localparam bit c_CHECK_EN = 1'b1;
`else
    localparam bit c_CHECK_EN = 1'b0;
`endif

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"},  {31'd0, out_valid}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy},      32'd0);
        chk({tag, "_readout"},{31'd0, readout},   32'd0);
        chk({tag, "_done"},   {31'd0, done},      32'd0);
        chk({tag, "_last"},   {31'd0, out_last},  32'd0);
        chk({tag, "_ierr"},   {31'd0, index_err}, 32'd0);
        chk({tag, "_data"},   {16'd0, out_data},  32'd0);
    endtask

    // One polynomial readout. abort_at >= 0 asserts reset once that many
    // words have been accepted; restarts re-pulses start at words 5 and 40.
    task automatic run_poly(input string tag, input int rmode, input bit det,
                            input int inj, input bit restarts, input int abort_at,
                            output int cycles);
        int start_cyc;
        bit r5, r40, got;
        prod_idx = 0; acc = 0; done_cnt = 0; rd_cnt = 0; exp_q.delete();
        ready_mode = rmode; ready_phase = 0; det_mode = det; inject_idx = inj;
        r5 = 0; r40 = 0; got = 0; cycles = 0;
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk); #1;
            if (abort_at >= 0 && acc >= abort_at) begin
                @(posedge clk); #1;
                reset = 1'b0;
                @(posedge clk); #1;
                check_reset_state({tag, "_abort"});
                chk({tag, "_abort_no_done"}, done_cnt, 0);
                reset = 1'b1;
                exp_q.delete();
                return;
            end
            if (inj >= 0 && acc == 2) chk({tag, "_ierr_before"}, {31'd0, index_err}, 32'd0);
            if (inj >= 0 && acc == 9) chk({tag, "_ierr_after"}, {31'd0, index_err}, {31'd0, c_CHECK_EN});
            if (restarts && !r5 && acc >= 5) begin
                r5 = 1; start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end
            if (restarts && !r40 && acc >= 40) begin
                r40 = 1; start = 1'b1; @(posedge clk); #1; start = 1'b0;
            end
            if (done_cnt > 0) got = 1;
        end
        chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_words"}, acc, NW);
        chk({tag, "_readouts"}, rd_cnt, NP);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_ierr_end"}, {31'd0, index_err}, {31'd0, (inj >= 0) && c_CHECK_EN});
        cycles = done_cyc - start_cyc + 1;
    endtask

    int cycles;
    int k2;
    int s2_cyc;
    bit got2;

    initial begin
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b1;

        run_poly("t1", 0, 1'b1, -1, 1'b0, -1, cycles);
        chk("t1_start_to_done", cycles, 4 * NP + 2);

        run_poly("t2", 1, 1'b1, -1, 1'b0, -1, cycles);
        run_poly("t2r", 2, 1'b0, -1, 1'b0, -1, cycles);

        run_poly("t3a", 0, 1'b1, -1, 1'b0, 11, cycles);
        run_poly("t3b", 0, 1'b1, -1, 1'b0, -1, cycles);
        chk("t3b_start_to_done", cycles, 4 * NP + 2);

        run_poly("t4", 0, 1'b1, -1, 1'b1, -1, cycles);
        chk("t4_start_to_done", cycles, 4 * NP + 2);

        run_poly("t5", 2, 1'b1, 4, 1'b0, -1, cycles);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("t5_ierr_cleared", {31'd0, index_err}, 32'd0);
        reset = 1'b1;

        // DEPTH=2 instance: 8 words, ready always high.
        p2 = 0; k2 = 0; got2 = 0;
        @(posedge clk); #1;
        start2 = 1'b1;
        s2_cyc = cyc;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int i = 0; i < 200 && !got2; i++) begin
            @(negedge clk);
            if (out2_valid) begin
                chk("d2_data", {16'd0, out2_data}, k2);
                chk("d2_last", {31'd0, out2_last}, {31'd0, k2 == 7});
                k2++;
            end
            if (done2) begin
                got2 = 1;
                chk("d2_start_to_done", cyc - s2_cyc + 1, 18);
            end
        end
        chk("d2_done_seen", {31'd0, got2}, 32'd1);
        chk("d2_words", k2, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/polyvec_readout_serializer.md
Name: polyvec_readout_serializer

Overview:
- Consumer on the readout side of polyvec_basemul_acc_mont.
- Requests accumulated coefficient pairs (polyvec_dout_1 / polyvec_dout_2, tagged by out_index) one index at a time.
- Re-emits them as a single 16-bit coefficient stream with valid/ready backpressure: dout_1 first, then dout_2, for index 0 .. 2^DEPTH-1.
- Sits between the basemul accumulator and the downstream invNTT / pack logic, throttling the accumulator via readout.

Parameters:
DEPTH  5  index width; one polynomial = 2^DEPTH coefficient pairs = 2^(DEPTH+1) output words
WIDTH  16  coefficient width

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block
start  in  1  pulse: begin reading one polynomial out of the accumulator
readout  out  1  request strobe to accumulator; one-cycle pulse per pair
in_dout_1  in  WIDTH  accumulator polyvec_dout_1 (even coefficient)
in_dout_2  in  WIDTH  accumulator polyvec_dout_2 (odd coefficient)
in_index  in  DEPTH  accumulator out_index for the presented pair
out_data  out  WIDTH  serialized coefficient
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data when out_valid&&out_ready
out_last  out  1  high with the final word (odd coefficient of index 2^DEPTH-1)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last word is accepted
index_err  out  1  sticky index mismatch flag (see Optional Feature)

Behaviour:
- Reset (reset==0): state=IDLE, pair counter cnt=0. readout, out_valid, out_last, busy, done and index_err are 0; out_data=0.
- FSM states: IDLE, REQ, CAP, EMIT_LO, EMIT_HI, FIN.
- IDLE: start==1 -> REQ, cnt=0. start is ignored in every other state.
- REQ: readout=1 for exactly this cycle -> CAP.
- CAP: producer contract is a fixed one-cycle latency. Latch in_dout_1 into lo_reg and in_dout_2 into hi_reg -> EMIT_LO.
- EMIT_LO: out_valid=1, out_data=lo_reg. On out_ready -> EMIT_HI.
- EMIT_HI: out_valid=1, out_data=hi_reg, out_last=(cnt==2^DEPTH-1).
  - On out_ready with last: -> FIN.
  - On out_ready otherwise: cnt<=cnt+1 (wraps to 0 only at FIN), -> REQ.
- FIN: done=1 for this cycle, busy=1 -> IDLE.
- Latency: with out_ready held high, start sampled at edge N gives readout high in cycle N+1 and the first out_valid in cycle N+3. Each pair then costs 4 cycles; a full polynomial takes 4*2^DEPTH+2 cycles from start to done.
- Stall rule: while out_valid && !out_ready, out_data and out_last are stable and no readout is issued. At most one pair is buffered.
- out_valid is registered; out_data is never changed without a handshake.
- Reset asserted mid-operation: abandon immediately and return to IDLE with the reset values above. No partial done is produced.
- in_index is only sampled in CAP.

Optional Feature:
- Macro: POLYVEC_READOUT_INDEX_CHECK_EN.
- Defined:
  - In CAP, compare in_index against cnt. On mismatch, set index_err; it stays 1 until reset.
  - Data flow is unaffected: the pair is still emitted.
- Undefined: no comparator is compiled, in_index is unused, and index_err is tied to 0.

Test Plan:
1. DEPTH=5, out_ready=1 throughout, producer model returns dout_1=2*idx, dout_2=2*idx+1 one cycle after readout -> 64 words 0..63 in order; out_last only on 63; 32 readout pulses; done pulses one cycle after word 63; busy=0 afterwards.
2. Same stimulus with out_ready toggling 1,0,0,1 -> identical 64-word sequence; out_data stable across every stalled cycle; readout never issued while a pair is pending.
3. reset driven 0 after word 10 is accepted -> next cycle out_valid=0, busy=0, readout=0. A new start yields the full sequence from word 0 and a single done.
4. start re-pulsed at words 5 and 40 -> ignored; the sequence and the done timing are unchanged.
5. Macro defined, producer returns in_index=3 when cnt=4 -> index_err=1 from the cycle after CAP until reset; data is still 8,9 for that pair. Macro undefined, same stimulus -> index_err=0.
6. DEPTH=2 -> 8 words 0..7; out_last on word 7; start-to-done 18 cycles with out_ready=1.
